// File: rtl/scalar_fetch_unit.sv
// scalar_fetch_unit: one-outstanding instruction fetch sequencer in front of Program_Counter.
// Buffers {pc, instr} pairs for scalar decode and handles branch redirects from the ALU.
module scalar_fetch_unit #(
    parameter int                ADDR_W     = 8,
    parameter int                INSTR_W    = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  PC_OUT,
    output logic               SET_PC,
    output logic [ADDR_W-1:0]  PC_IN,
    input  logic               BRANCH_TAKEN,
    input  logic [ADDR_W-1:0]  BRANCH_TARGET,
    output logic               IMEM_REQ,
    output logic [ADDR_W-1:0]  IMEM_ADDR,
    input  logic               IMEM_ACK,
    input  logic [INSTR_W-1:0] IMEM_RDATA,
    output logic               INSTR_VALID,
    output logic [INSTR_W-1:0] INSTR_DATA,
    output logic [ADDR_W-1:0]  INSTR_PC,
    input  logic               INSTR_READY
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        SETTLE,
        REQ,
        DISCARD
    } state_t;

    state_t             state;
    logic [INSTR_W-1:0] fifo_data [FIFO_DEPTH];
    logic [ADDR_W-1:0]  fifo_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_after_pop;
    logic               push;
    logic               pop;
    logic               can_issue;

    assign INSTR_VALID     = (count != '0);
    assign INSTR_DATA      = fifo_data[rd_ptr];
    assign INSTR_PC        = fifo_pc[rd_ptr];
    assign pop             = INSTR_VALID & INSTR_READY & ~BRANCH_TAKEN;
    assign push            = (state == REQ) & IMEM_ACK & ~BRANCH_TAKEN;
    assign count_after_pop = count - CNT_W'(pop);
    assign can_issue       = count_after_pop < CNT_W'(FIFO_DEPTH);

    // A request waits while SET_PC is high so PC_OUT has picked up the new PC before it is latched.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= SETTLE;
            SET_PC    <= 1'b1;
            PC_IN     <= RESET_PC;
            IMEM_REQ  <= 1'b0;
            IMEM_ADDR <= '0;
        end else begin
            SET_PC <= 1'b0;
            case (state)
                SETTLE: begin
                    if (!BRANCH_TAKEN && !SET_PC && can_issue) begin
                        IMEM_ADDR <= PC_OUT;
                        IMEM_REQ  <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (IMEM_ACK) begin
                        IMEM_REQ <= 1'b0;
                        state    <= SETTLE;
                        if (!BRANCH_TAKEN) begin
                            SET_PC <= 1'b1;
                            PC_IN  <= IMEM_ADDR + ADDR_W'(4);
                        end
                    end else if (BRANCH_TAKEN) begin
                        state <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (IMEM_ACK) begin
                        IMEM_REQ <= 1'b0;
                        state    <= SETTLE;
                    end
                end
                default: state <= SETTLE;
            endcase
            if (BRANCH_TAKEN) begin
                SET_PC <= 1'b1;
                PC_IN  <= BRANCH_TARGET;
            end
        end
    end

    // A redirect flushes the buffer and overrides any same-cycle pop or push.
    always_ff @(posedge clock) begin
        if (reset || BRANCH_TAKEN) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_data[wr_ptr] <= IMEM_RDATA;
            fifo_pc[wr_ptr]   <= IMEM_ADDR;
        end
    end

endmodule
